relational_serial_seq: RTL and testbench

- Upstream sequencer for the 1-bit relational comparator stage (inputs a, b; outputs gt, lt, eq).
- Accepts two WIDTH-bit unsigned operands over a valid/ready handshake.
- Presents the operand bit pairs MSB-first to the comparator, one pair per cycle, and reads back its gt/lt/eq flags each cycle.
- Produces a registered WIDTH-bit magnitude-compare result with early termination on the first differing bit.

---
 rtl/relational_serial_seq.sv | 139 +++++++++++++
 tb/tb_relational_serial_seq.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/relational_serial_seq.sv
// Serial MSB-first magnitude-compare sequencer. It feeds operand bit pairs to an
// external 1-bit relational comparator and stops at the first pair that differs.
module relational_serial_seq #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             cmp_a,
  output logic             cmp_b,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             res_gt,
  output logic             res_lt,
  output logic             res_eq,
  output logic             res_err,
  output logic [CW-1:0]    res_bits
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] sh_a_reg, sh_a_next;
  logic [WIDTH-1:0] sh_b_reg, sh_b_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [CW-1:0]    bits_reg, bits_next;
  logic             res_gt_reg, res_gt_next;
  logic             res_lt_reg, res_lt_next;
  logic             res_eq_reg, res_eq_next;
  logic             res_err_reg, res_err_next;
  logic [CW-1:0]    res_bits_reg, res_bits_next;

  logic [2:0] flags;
  logic       flags_onehot;

  assign flags        = {cmp_gt, cmp_lt, cmp_eq};
  assign flags_onehot = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);

  // in_ready is gated by rst_n so that it stays low while reset is held.
  assign in_ready  = rst_n && (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign cmp_a     = (state_reg == SHIFT) && sh_a_reg[WIDTH-1];
  assign cmp_b     = (state_reg == SHIFT) && sh_b_reg[WIDTH-1];
  assign res_gt    = res_gt_reg;
  assign res_lt    = res_lt_reg;
  assign res_eq    = res_eq_reg;
  assign res_err   = res_err_reg;
  assign res_bits  = res_bits_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      sh_a_reg     <= '0;
      sh_b_reg     <= '0;
      cnt_reg      <= '0;
      bits_reg     <= '0;
      res_gt_reg   <= 1'b0;
      res_lt_reg   <= 1'b0;
      res_eq_reg   <= 1'b0;
      res_err_reg  <= 1'b0;
      res_bits_reg <= '0;
    end else begin
      state_reg    <= state_next;
      sh_a_reg     <= sh_a_next;
      sh_b_reg     <= sh_b_next;
      cnt_reg      <= cnt_next;
      bits_reg     <= bits_next;
      res_gt_reg   <= res_gt_next;
      res_lt_reg   <= res_lt_next;
      res_eq_reg   <= res_eq_next;
      res_err_reg  <= res_err_next;
      res_bits_reg <= res_bits_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    sh_a_next     = sh_a_reg;
    sh_b_next     = sh_b_reg;
    cnt_next      = cnt_reg;
    bits_next     = bits_reg;
    res_gt_next   = res_gt_reg;
    res_lt_next   = res_lt_reg;
    res_eq_next   = res_eq_reg;
    res_err_next  = res_err_reg;
    res_bits_next = res_bits_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          sh_a_next     = op_a;
          sh_b_next     = op_b;
          cnt_next      = CW'(WIDTH - 1);
          bits_next     = '0;
          res_gt_next   = 1'b0;
          res_lt_next   = 1'b0;
          res_eq_next   = 1'b0;
          res_err_next  = 1'b0;
          res_bits_next = '0;
          state_next    = SHIFT;
        end
      end
      SHIFT: begin
        if (!flags_onehot) begin
          res_err_next  = 1'b1;
          res_bits_next = bits_reg + CW'(1);
          state_next    = DONE;
        end else if (cmp_gt || cmp_lt) begin
          // First differing pair decides the result; remaining bits are skipped.
          res_gt_next   = cmp_gt;
          res_lt_next   = cmp_lt;
          res_bits_next = bits_reg + CW'(1);
          state_next    = DONE;
        end else if (cnt_reg == '0) begin
          res_eq_next   = 1'b1;
          res_bits_next = CW'(WIDTH);
          state_next    = DONE;
        end else begin
          sh_a_next = {sh_a_reg[WIDTH-2:0], 1'b0};
          sh_b_next = {sh_b_reg[WIDTH-2:0], 1'b0};
          cnt_next  = cnt_reg - CW'(1);
          bits_next = bits_reg + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_relational_serial_seq.sv
// Bench for relational_serial_seq: directed cases plus random operand pairs,
// with a behavioural comparator (fault-injectable) and a reference compare model.
module tb_relational_serial_seq;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  op_a, op_b;
  logic          cmp_a, cmp_b, cmp_gt, cmp_lt, cmp_eq;
  logic          out_valid, out_ready;
  logic          res_gt, res_lt, res_eq, res_err;
  logic [CW-1:0] res_bits;

  logic          fault_active;
  logic [2:0]    fault_flags;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign cmp_gt = fault_active ? fault_flags[2] : (cmp_a & ~cmp_b);
  assign cmp_lt = fault_active ? fault_flags[1] : (~cmp_a & cmp_b);
  assign cmp_eq = fault_active ? fault_flags[0] : ~(cmp_a ^ cmp_b);

  relational_serial_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .op_a(op_a), .op_b(op_b),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_gt(cmp_gt), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq),
    .out_valid(out_valid), .out_ready(out_ready),
    .res_gt(res_gt), .res_lt(res_lt), .res_eq(res_eq), .res_err(res_err),
    .res_bits(res_bits)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected {gt,lt,eq,err,bits}: first differing MSB-relative index decides,
  // unless an injected fault is reached first.
  function automatic logic [7:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input int fpos);
    int k = W;
    for (int i = 0; i < W; i++)
      if (a[W-1-i] != b[W-1-i]) begin k = i; break; end
    if (fpos >= 0 && fpos <= k && fpos < W) return {4'b0001, 4'(fpos + 1)};
    if (k < W) return {(a > b), (a < b), 2'b00, 4'(k + 1)};
    return {4'b0010, 4'(W)};
  endfunction

  function automatic logic [7:0] res_vec();
    return {res_gt, res_lt, res_eq, res_err, res_bits};
  endfunction

  task automatic run_compare(input logic [W-1:0] a, input logic [W-1:0] b, input int fpos,
                             input logic [2:0] fflags, input int stall);
    logic [7:0] expv;
    int nsh;
    int guard;
    expv  = ref_result(a, b, fpos);
    nsh   = int'(expv[3:0]);
    guard = 0;
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    check("ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1; op_a = a; op_b = b;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; op_a = W'($urandom); op_b = W'($urandom);
    for (int p = 0; p < nsh; p++) begin
      check($sformatf("shift%0d", p), {out_valid, in_ready, cmp_a, cmp_b},
            {2'b00, a[W-1-p], b[W-1-p]});
      fault_flags  = fflags;
      fault_active = (p == fpos);
      @(posedge clk);
      #1 fault_active = 1'b0;
      @(negedge clk);
    end
    out_ready = (stall == 0);
    check("result", {out_valid, in_ready, cmp_a, cmp_b, res_vec()}, {4'b1000, expv});
    for (int s = 1; s <= stall; s++) begin
      @(posedge clk); @(negedge clk);
      check("hold", {out_valid, in_ready, cmp_a, cmp_b, res_vec()}, {4'b1000, expv});
      in_valid = 1'b1; op_a = W'($urandom); op_b = W'($urandom);
      out_ready = (s == stall);
    end
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    check("handoff", {out_valid, in_ready, cmp_a, cmp_b, res_vec()}, {4'b0100, expv});
    $display("txn a=%02h b=%02h fpos=%0d stall=%0d exp=%02h got=%02h", a, b, fpos, stall,
             expv, res_vec());
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [2:0]   ff;
    int           mode, fp;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op_a = '0; op_b = '0;
    fault_active = 1'b0; fault_flags = 3'b000;
    #3;
    check("reset_hold", {out_valid, in_ready, cmp_a, cmp_b, res_vec()}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1 check("reset_release", {out_valid, in_ready, cmp_a, cmp_b, res_vec()}, 32'h400);

    run_compare(8'hA5, 8'h25, -1, 3'b000, 0);
    run_compare(8'h3C, 8'h3D, -1, 3'b000, 0);
    run_compare(8'h5A, 8'h5A, -1, 3'b000, 0);
    run_compare(8'h00, 8'h00, -1, 3'b000, 0);
    run_compare(8'hFF, 8'hFF, -1, 3'b000, 0);
    run_compare(8'h80, 8'h7F, -1, 3'b000, 5);
    run_compare(8'h12, 8'h34, -1, 3'b000, 0);
    run_compare(8'hF0, 8'hF0, 3, 3'b000, 0);
    run_compare(8'hF0, 8'hF0, 3, 3'b110, 0);

    // Asynchronous reset on the third SHIFT cycle aborts the compare.
    in_valid = 1'b1; op_a = 8'h01; op_b = 8'h00;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    check("pre_reset_shift", {out_valid, cmp_a, cmp_b}, 32'd0);
    rst_n = 1'b0;
    #1 check("mid_reset", {out_valid, in_ready, cmp_a, cmp_b, res_vec()}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("post_reset_idle", {out_valid, in_ready, cmp_a, cmp_b, res_vec()}, 32'h400);
      @(negedge clk);
    end
    run_compare(8'h01, 8'h00, -1, 3'b000, 0);

    for (int t = 0; t < 30; t++) begin
      ra   = W'($urandom);
      mode = $urandom_range(0, 3);
      fp   = -1;
      ff   = 3'b000;
      case (mode)
        0: rb = W'($urandom);
        1: rb = ra;
        2: rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
        default: begin
          rb = ra;
          fp = $urandom_range(0, W - 1);
          case ($urandom_range(0, 4))
            0: ff = 3'b000;
            1: ff = 3'b110;
            2: ff = 3'b011;
            3: ff = 3'b101;
            default: ff = 3'b111;
          endcase
        end
      endcase
      run_compare(ra, rb, fp, ff, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
